// File: rtl/prod_accumulator_pkg.sv
// Shared constants for the product accumulator slice.
// Holds the default widths, the product width and the FSM state encoding.
package prod_accumulator_pkg;

  localparam int unsigned ACC_W_DEF = 11;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned PROD_W    = 8;

  typedef logic [0:0] state_t;

  localparam state_t ACCUM = 1'b0;
  localparam state_t DONE  = 1'b1;

endpackage

// File: rtl/prod_accumulator_if.sv
// Handshake bundle between the product source/result sink and the accumulator.
//   in_valid/in_ready/in_prod : product stream into the accumulator
//   out_valid/out_ready       : batch result handshake
//   out_sum/out_ovf           : batch total and sticky overflow flag
// master = environment side, slave = accumulator side.
interface prod_accumulator_if #(
  parameter int unsigned ACC_W = prod_accumulator_pkg::ACC_W_DEF
);
  import prod_accumulator_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/prod_accumulator_acc_add_sat.sv
// Accumulator adder: returns the next running sum and the carry out.
// With ACC_SATURATE_EN defined the sum clamps to all-ones on carry; otherwise
// it wraps modulo 2^ACC_W.
//   a       : current running sum
//   b       : zero-extended product
//   sum_c   : next running sum (combinational)
//   carry_c : carry out of ACC_W bits (combinational)
module acc_add_sat #(
  parameter int unsigned ACC_W = prod_accumulator_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum_c,
  output logic             carry_c
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry_c  = full_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, further adds keep carrying (or add zero), so the sum holds.
  assign sum_c = carry_c ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_c = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Batch multiply-accumulate back end: sums batch_len products arriving over a
// valid/ready stream and presents each batch total on a valid/ready output.
// Optional feature macro: ACC_SATURATE_EN (clamp instead of wrap on overflow).
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort; zeroes the batch and drops any result
//   batch_len  : products per batch, 0 means 2^CNT_W; sampled on first accept
//   io         : slave side of the product / result handshake bundle
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [CNT_W-1:0]  batch_len,
  prod_accumulator_if.slave io
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q,   sum_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0]   len_q,   len_d;
  logic               ovf_q,   ovf_d;

  logic               accept;
  logic               first;
  logic               last;
  logic [CNT_W-1:0]   len_eff;
  logic [ACC_W-1:0]   add_sum_c;
  logic               add_carry_c;

  // Handshake flags are decoded straight from the state register.
  assign io.in_ready  = (state_q == ACCUM);
  assign io.out_valid = (state_q == DONE);
  assign io.out_sum   = sum_q;
  assign io.out_ovf   = ovf_q;

  assign accept  = io.in_valid & (state_q == ACCUM);
  assign first   = (cnt_q == '0);
  // The first product of a batch uses the live batch_len, later ones the latch.
  assign len_eff = first ? batch_len : len_q;
  // Length 0 wraps to all-ones, ending the batch after 2^CNT_W products.
  assign last    = (cnt_q == CNT_W'(len_eff - CNT_W'(1)));

  acc_add_sat #(.ACC_W(ACC_W)) u_add (
    .a       (sum_q),
    .b       (ACC_W'(io.in_prod)),
    .sum_c   (add_sum_c),
    .carry_c (add_carry_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; clear overrides everything.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = ACCUM;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            sum_d = add_sum_c;
            ovf_d = ovf_q | add_carry_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (first) len_d = batch_len;
            if (last) state_d = DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state_d = ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: directed scenarios followed by
// randomized stalls, checked against a batch-level arithmetic model.
module tb_prod_accumulator;

  localparam int unsigned ACC_W = 11;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [CNT_W-1:0] batch_len;

  prod_accumulator_if #(.ACC_W(ACC_W)) bus ();

  prod_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .batch_len (batch_len),
    .io        (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: a batch is a count of products and their plain integer total.
  bit          m_done;
  int unsigned m_cnt;
  int unsigned m_len;
  int unsigned m_total;
  int unsigned batches_done;

  function automatic logic [ACC_W-1:0] exp_sum(int unsigned t);
`ifdef ACC_SATURATE_EN
    return (t > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(t);
`else
    return ACC_W'(t % (ACC_MAX + 1));
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done  = 1'b0;
    m_cnt   = 0;
    m_total = 0;
  endtask

  // Advance the model with the current inputs, clock once, compare outputs.
  task automatic tick();
    if (clear) begin
      model_reset();
    end else if (!m_done) begin
      if (bus.in_valid) begin
        if (m_cnt == 0) m_len = (batch_len == 0) ? (1 << CNT_W) : int'(batch_len);
        m_total += bus.in_prod;
        m_cnt++;
        if (m_cnt == m_len) m_done = 1'b1;
      end
    end else if (bus.out_ready) begin
      model_reset();
      batches_done++;
    end
    @(posedge clk);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_done));
    check("out_valid", 32'(bus.out_valid), 32'(m_done));
    if (m_done) begin
      check("out_sum", 32'(bus.out_sum), 32'(exp_sum(m_total)));
      check("out_ovf", 32'(bus.out_ovf), 32'(m_total > ACC_MAX));
    end
  endtask

  task automatic send(logic [7:0] p);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int unsigned cycles;
    logic [ACC_W-1:0] big_exp;

    rst_n         = 1'b0;
    clear         = 1'b0;
    batch_len     = '0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    m_len         = 0;
    batches_done  = 0;
    model_reset();

    // Reset state.
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-batch loses the partial sum immediately.
    batch_len = 4'd3;
    send(8'd100);
    send(8'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_sum", 32'(bus.out_sum), 32'd0);
    check("arst_out_ovf", 32'(bus.out_ovf), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Batch of 3 with the result held by out_ready low.
    batch_len = 4'd3;
    send(8'd6);
    send(8'd12);
    send(8'd35);
    check("b3_sum", 32'(bus.out_sum), 32'd53);
    for (int i = 0; i < 4; i++) tick();
    check("b3_hold_sum", 32'(bus.out_sum), 32'd53);
    check("b3_hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();

    // batch_len 0 means 16; a mid-batch change to 2 is ignored.
    batch_len = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) batch_len = 4'd2;
      if (i == 15) check("b16_not_early", 32'(bus.out_valid), 32'd0);
      send(8'd1);
    end
    check("b16_sum", 32'(bus.out_sum), 32'd16);
    tick();

    // Overflow: ten products of 225, total 2250.
    batch_len = 4'd10;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'd225);
`ifdef ACC_SATURATE_EN
    big_exp = ACC_W'(2047);
`else
    big_exp = ACC_W'(202);
`endif
    check("ovf_sum", 32'(bus.out_sum), 32'(big_exp));
    check("ovf_flag", 32'(bus.out_ovf), 32'd1);
    bus.out_ready = 1'b1;
    tick();

    // Clear after two products; the product presented with clear is dropped.
    batch_len = 4'd3;
    send(8'd6);
    send(8'd7);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd9;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'd5);
    check("clr_sum", 32'(bus.out_sum), 32'd15);
    check("clr_ovf", 32'(bus.out_ovf), 32'd0);

    // Clear while a result is pending.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_done_valid", 32'(bus.out_valid), 32'd0);

    // Random stalls over 50 batches.
    batches_done = 0;
    cycles       = 0;
    while (batches_done < 50 && cycles < 5000) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_prod   = 8'($urandom % 256);
      bus.out_ready = ($urandom % 3) != 0;
      batch_len     = CNT_W'($urandom % 16);
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    check("rand_batches", batches_done, 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
